// File: rtl/mem_stage.sv
// mem_stage: MIPS data-memory stage with byte/half/word loads and stores, power-on RAM clear and misalignment fault capture
// Ports: CLK clock; RST sync active-high reset; Ins instruction (opcode Ins[31:26]);
//   Result effective address or pass-through value; Rdata2 store data; Wdata write-back value;
//   Busy high while the RAM is being cleared; Fault/FaultAddr sticky flag and address of the first misaligned access.
// Build option: MEM_MISALIGN_TRAP_EN enables misalignment detection; when undefined, offset bits below the access size are ignored.
module mem_stage #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Ins,
  input  logic [31:0] Result,
  input  logic [31:0] Rdata2,
  output logic [31:0] Wdata,
  output logic        Busy,
  output logic        Fault,
  output logic [31:0] FaultAddr
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state;
  logic [DEPTH_LOG2-1:0] p;
  logic [31:0] mem [DEPTH];
  logic [5:0] op;
  logic [DEPTH_LOG2-1:0] widx;
  logic [1:0] o;
  logic is_load, is_store, is_half, is_word, is_signed, mis, we;
  logic [3:0] be;
  logic [31:0] w, wd, ld;
  logic [7:0] lb;
  logic [15:0] lh;
  logic unused;
  assign op = Ins[31:26];
  assign widx = Result[DEPTH_LOG2+1:2];
  assign o = Result[1:0];
  assign unused = ^{Ins[25:0], Result[31:DEPTH_LOG2+2]};
  assign is_load = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  assign is_store = op inside {6'h28, 6'h29, 6'h2B};
  assign is_half = op inside {6'h21, 6'h25, 6'h29};
  assign is_word = op inside {6'h23, 6'h2B};
  assign is_signed = op inside {6'h20, 6'h21};
  assign Busy = state == CLEAR;
`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = (is_half & o[0]) | (is_word & (o != 2'b00));
`else
  assign mis = 1'b0;
`endif
  // Word accesses ignore o and half accesses use only o[1], so without the trap the offset is simply truncated.
  assign w = mem[widx];
  assign lb = w[{o, 3'b000} +: 8];
  assign lh = o[1] ? w[31:16] : w[15:0];
  assign ld = is_word ? w : is_half ? {{16{is_signed & lh[15]}}, lh} : {{24{is_signed & lb[7]}}, lb};
  assign Wdata = !is_load ? Result : (Busy | mis) ? 32'd0 : ld;
  // Store data is replicated across lanes so the byte enables alone pick the destination.
  assign be = is_word ? 4'hF : is_half ? (o[1] ? 4'hC : 4'h3) : 4'b0001 << o;
  assign wd = is_word ? Rdata2 : is_half ? {2{Rdata2[15:0]}} : {4{Rdata2[7:0]}};
  assign we = is_store & !Busy & !mis & !RST;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= CLEAR;
      p <= '0;
    end else if (state == CLEAR) begin
      p <= p + 1'b1;
      if (p == '1) state <= IDLE;
    end
  end
  always_ff @(posedge CLK) begin
    if (Busy & !RST) mem[p] <= '0;
    else if (we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[widx][8*i +: 8] <= wd[8*i +: 8];
  end
`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      Fault <= 1'b0;
      FaultAddr <= '0;
    end else if (!Busy & mis & !Fault) begin
      Fault <= 1'b1;
      FaultAddr <= Result;
    end
  end
`else
  assign Fault = 1'b0;
  assign FaultAddr = '0;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized and directed check of mem_stage against a byte-addressed memory model
module tb_mem_stage;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic CLK = 1'b0, RST = 1'b1;
  logic [31:0] Ins = '0, Result = '0, Rdata2 = '0;
  logic [31:0] Wdata, FaultAddr;
  logic Busy, Fault;
  logic [7:0] mb [1024];
  logic mfault;
  logic [31:0] mfaddr, got, old;
  int n_cmp = 0, n_err = 0, n;
  logic [5:0] ops [11] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h00, 6'h0F, 6'h08};

  mem_stage dut (.CLK(CLK), .RST(RST), .Ins(Ins), .Result(Result), .Rdata2(Rdata2),
                 .Wdata(Wdata), .Busy(Busy), .Fault(Fault), .FaultAddr(FaultAddr));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (mb[i]) mb[i] = 8'h00;
    mfault = 1'b0;
    mfaddr = '0;
  endtask

  task automatic do_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                       output logic [31:0] obs);
    int sz, eff, off, base;
    bit ld, st, sgn, mis;
    logic [63:0] v;
    logic [31:0] exp;
    chk("busy", {31'b0, Busy}, 32'd0);
    chk("fault", {31'b0, Fault}, {31'b0, mfault});
    chk("faultaddr", FaultAddr, mfaddr);
    ld = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    st = op inside {6'h28, 6'h29, 6'h2B};
    sz = (op inside {6'h20, 6'h24, 6'h28}) ? 1 : (op inside {6'h21, 6'h25, 6'h29}) ? 2 : 4;
    sgn = op inside {6'h20, 6'h21};
    eff = int'(addr & 32'h3FF);
    off = eff % sz;
    mis = TRAP && (ld || st) && off != 0;
    base = eff - off;
    Ins = {op, 26'($urandom)};
    Result = addr;
    Rdata2 = data;
    #1;
    v = '0;
    for (int k = 0; k < sz; k++) v = v | (64'(mb[base+k]) << (8*k));
    if (sgn && v[8*sz-1]) v = v | ~((64'd1 << (8*sz)) - 64'd1);
    exp = !ld ? addr : mis ? 32'd0 : v[31:0];
    obs = Wdata;
    chk($sformatf("wdata op=%h addr=%h", op, addr), obs, exp);
    if (st && !mis)
      for (int k = 0; k < sz; k++) mb[base+k] = 8'(data >> (8*k));
    if (mis && !mfault) begin
      mfault = 1'b1;
      mfaddr = addr;
    end
    @(negedge CLK);
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (Busy === 1'b1 && cnt < 2000) begin
      if (cnt == 10) begin
        Ins = {6'h2B, 26'd0};
        Result = 32'h0;
        Rdata2 = 32'hFFFFFFFF;
      end else if (cnt == 20) begin
        Ins = {6'h23, 26'd0};
        Result = 32'h0;
        #1;
        chk("busy_load", Wdata, 32'd0);
      end else Ins = '0;
      cnt++;
      @(negedge CLK);
    end
    Ins = '0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge CLK);
    chk("rst_busy", {31'b0, Busy}, 32'd1);
    chk("rst_fault", {31'b0, Fault}, 32'd0);
    chk("rst_faultaddr", FaultAddr, 32'd0);
    RST = 1'b0;
    count_busy(n);
    chk("clear_cycles", n, 32'd256);
    for (int i = 0; i < 4; i++) begin
      do_op(6'h23, $urandom & 32'hFFFFFFFC, 32'd0, got);
      chk("post_clear_lw", got, 32'd0);
    end
    do_op(6'h2B, 32'h10, 32'h11223344, got);
    do_op(6'h20, 32'h13, 32'd0, got);
    chk("lb13", got, 32'h00000011);
    do_op(6'h24, 32'h10, 32'd0, got);
    chk("lbu10", got, 32'h00000044);
    do_op(6'h21, 32'h12, 32'd0, got);
    chk("lh12", got, 32'h00001122);
    do_op(6'h23, 32'h10, 32'd0, got);
    chk("lw10", got, 32'h11223344);
    do_op(6'h2B, 32'h20, 32'hFFFFFFFF, got);
    do_op(6'h28, 32'h21, 32'h00000080, got);
    do_op(6'h23, 32'h20, 32'd0, got);
    chk("lw20", got, 32'hFFFF80FF);
    do_op(6'h20, 32'h21, 32'd0, got);
    chk("lb21", got, 32'hFFFFFF80);
    do_op(6'h2B, 32'h400, 32'hCAFEBABE, got);
    do_op(6'h23, 32'h000, 32'd0, got);
    chk("alias", got, 32'hCAFEBABE);
    do_op(6'h23, 32'h30, 32'd0, old);
    do_op(6'h2B, 32'h31, 32'hDEAD0000, got);
    chk("fault_set", {31'b0, Fault}, {31'b0, TRAP});
    chk("fault_addr", FaultAddr, TRAP ? 32'h31 : 32'h0);
    do_op(6'h23, 32'h30, 32'd0, got);
    chk("mis_store_word", got, TRAP ? old : 32'hDEAD0000);
    do_op(6'h21, 32'h45, 32'd0, got);
    chk("fault_addr_sticky", FaultAddr, TRAP ? 32'h31 : 32'h0);
    do_op(6'h00, 32'h12345678, 32'd0, got);
    chk("addu_pass", got, 32'h12345678);
    for (int i = 0; i < 400; i++)
      do_op(ops[$urandom_range(0, 10)], ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63)), $urandom, got);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    model_reset();
    RST = 1'b0;
    repeat (100) @(negedge CLK);
    chk("mid_clear_busy", {31'b0, Busy}, 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_clear_fault", {31'b0, Fault}, 32'd0);
    RST = 1'b0;
    count_busy(n);
    chk("restart_cycles", n, 32'd256);
    do_op(6'h23, 32'h0, 32'd0, got);
    chk("suppressed_store", got, 32'd0);
    for (int i = 0; i < 16; i++) do_op(6'h23, ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63)), 32'd0, got);
    for (int i = 0; i < 200; i++)
      do_op(ops[$urandom_range(0, 10)], ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63)), $urandom, got);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Data-memory stage of the single-cycle MIPS datapath, directly downstream of the execute stage. It takes the execute-stage `Result` as the effective address and `Rdata2` as store data. It performs byte, halfword and word loads and stores against an on-chip word-organised RAM, and produces the register write-back value. A power-on clear sequencer zeroes the RAM after reset, and a sticky fault register records misaligned accesses.

## Interface
- `DEPTH_LOG2`, 8, log2 of RAM depth in 32-bit words (default 256 words / 1 KiB).
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  reset, synchronous, active-high; clock CLK.
- `Ins`  in  32  current instruction; `Ins[31:26]` selects the access type.
- `Result`  in  32  execute-stage result: the effective address for loads/stores, the pass-through value otherwise.
- `Rdata2`  in  32  store data (rt).
- `Wdata`  out  32  write-back value: the extended load data for loads, otherwise `Result`.
- `Busy`  out  1  high while the clear sequencer runs; the fetch stage holds PC while high.
- `Fault`  out  1  sticky misaligned-access flag.
- `FaultAddr`  out  32  address of the first faulting access since reset.

## Operation
- Opcodes:
  - loads: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25
  - stores: SB 0x28, SH 0x29, SW 0x2B
  - all other opcodes: no access, `Wdata`=`Result`.
- Addressing:
  - word index = `Result[DEPTH_LOG2+1:2]`; upper address bits are ignored (the RAM aliases).
  - byte offset `o` = `Result[1:0]`.
- Byte order is little-endian: the byte at offset k occupies word bits [8k+7:8k].
- Loads (combinational read of the addressed word `w`):
  - LB/LBU select byte o, sign- or zero-extended.
  - LH/LHU select half `o[1]`, sign- or zero-extended.
  - LW returns `w`.
- Stores:
  - SB writes `Rdata2[7:0]` into lane o.
  - SH writes `Rdata2[15:0]` into half `o[1]`.
  - SW writes the full word.
  - Unselected lanes are unchanged.
- Clear sequencer, states CLEAR and IDLE:
  - RST=1 forces CLEAR and pointer `p`=0.
  - In CLEAR with RST=0: write 0 to word p, then p←p+1.
  - After word 2^DEPTH_LOG2−1 is written, go to IDLE.
  - `Busy` = (state==CLEAR).
  - In CLEAR, instruction stores are suppressed and loads return 0 in `Wdata`.
- Fault register:
  - A misaligned access is LH/LHU/SH with o[0]=1, or LW/SW with o≠0.
  - On the first misaligned access in IDLE: `Fault`←1 and `FaultAddr`←`Result`.
  - Later faults do not overwrite `FaultAddr`.
  - A misaligned store does not modify the RAM.
  - A misaligned load returns `Wdata`=0.

## Timing
- Reset values: state CLEAR, `Busy`=1, `Fault`=0, `FaultAddr`=0, p=0. RAM contents are undefined until the clear sequence completes.
- The clear takes exactly 2^DEPTH_LOG2 cycles after RST falls. `Busy` is low from the cycle after the last clear write.
- RST asserted mid-clear restarts the clear from p=0.
- RST asserted in IDLE re-enters CLEAR and re-zeroes the RAM.
- Loads are zero-latency: `Wdata` is valid in the same cycle as `Ins`/`Result`.
- Stores commit at the rising edge that ends the instruction's cycle.
- Read of an address in the same cycle as a store to it returns the pre-store contents.
- `Fault`/`FaultAddr` update at the edge ending the faulting cycle.
- RST takes priority over a simultaneous fault capture.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined: misalignment detection, fault capture, store suppression and zeroed load data as specified above.
- Not defined:
  - `Fault` and `FaultAddr` are tied to 0.
  - Offset bits below the access size are ignored: LH/LHU/SH use `o[1]` only; LW/SW use `o`=0.
  - The access proceeds normally.

## Test plan
- RST high 2 cycles, then low → `Busy`=1 for exactly 256 cycles, then 0. LW of any address then returns 0.
- SW 0x11223344 @0x10; LB @0x13 → 0x00000011; LBU @0x10 → 0x00000044; LH @0x12 → 0x00001122; LW @0x10 → 0x11223344.
- SW 0xFFFFFFFF @0x20; SB 0x80 @0x21 → LW @0x20 = 0xFFFF80FF; LB @0x21 → 0xFFFFFF80.
- Aliasing: SW 0xCAFEBABE @0x400 → LW @0x000 = 0xCAFEBABE (DEPTH_LOG2=8).
- With `MEM_MISALIGN_TRAP_EN`: SW 0xDEAD0000 @0x31 → `Fault`=1, `FaultAddr`=0x31, word @0x30 unchanged. A later LH @0x45 leaves `FaultAddr`=0x31.
- RST pulsed at clear cycle 100 → `Busy` stays high for 256 further cycles after RST falls. Non-OP instructions (e.g. ADDU) give `Wdata`=`Result` once IDLE.
